// File: rtl/sw_alloc_rr_if.sv
// ---------------------------------------------------------------------------
// sw_alloc_rr_if
//   Handshake bundle between the router input stages and the switch
//   allocator. The allocator side uses the 'slave' modport; whoever drives
//   the flit requests and downstream credits (input buffers or a bench)
//   uses 'master'.
//
//   in_req      [NP]     input i holds a flit requesting traversal
//   in_port     [NP*PW]  requested output code of input i at [PW*i +: PW]
//   in_head     [NP]     input i's flit is a head flit
//   in_tail     [NP]     input i's flit is a tail flit (head&tail = single)
//   out_rdy     [NP]     output o has downstream credit this cycle
//   gnt         [NP]     combinational grant, flit of input i moves now
//   out_vld     [NP]     registered, output o carries a flit this cycle
//   xbar_sel    [NP*IW]  registered, input index driving output o
//   out_lock    [NP]     registered, output o held by a packet in flight
//   err_illegal [1]      registered pulse for a request with a bad code
// ---------------------------------------------------------------------------
interface sw_alloc_rr_if #(
  parameter int NP = 5,
  parameter int PW = 3,
  parameter int IW = 3
);
  logic [NP-1:0]    in_req;
  logic [NP*PW-1:0] in_port;
  logic [NP-1:0]    in_head;
  logic [NP-1:0]    in_tail;
  logic [NP-1:0]    out_rdy;
  logic [NP-1:0]    gnt;
  logic [NP-1:0]    out_vld;
  logic [NP*IW-1:0] xbar_sel;
  logic [NP-1:0]    out_lock;
  logic             err_illegal;

  modport master (
    output in_req, in_port, in_head, in_tail, out_rdy,
    input  gnt, out_vld, xbar_sel, out_lock, err_illegal
  );

  modport slave (
    input  in_req, in_port, in_head, in_tail, out_rdy,
    output gnt, out_vld, xbar_sel, out_lock, err_illegal
  );
endinterface

// File: rtl/sw_alloc_rr.sv
// ---------------------------------------------------------------------------
// sw_alloc_rr
//   Switch allocator for the 5-port 2D mesh router. Each output port runs an
//   independent round-robin arbiter over the inputs that request it, with
//   wormhole locking: once a non-tail flit is granted the output stays
//   reserved for that input until its tail is granted. Grants are
//   combinational; the crossbar select, valid and lock status are
//   registered (switch-traversal stage, one cycle after the grant).
//
//   Port codes: 001 LOCAL=0, 010 EAST=1, 011 WEST=2, 100 NORTH=3,
//   101 SOUTH=4. Codes 000, 110 and 111 are illegal, never granted, and
//   raise err_illegal on the following cycle.
//
//   clk_t  clock, rising edge
//   rst_t  asynchronous active-high reset; also forces gnt low while high
//   bus    sw_alloc_rr_if.slave (request/credit in, grant/crossbar out)
// ---------------------------------------------------------------------------
module sw_alloc_rr #(
  parameter int NP = 5,
  parameter int PW = 3,
  parameter int IW = 3
) (
  input logic         clk_t,
  input logic         rst_t,
  sw_alloc_rr_if.slave bus
);

  typedef enum logic {
    LK_FREE = 1'b0,
    LK_HELD = 1'b1
  } lock_e;

  // per-output arbitration state
  lock_e         lock_q  [NP];
  logic [IW-1:0] owner_q [NP];
  logic [IW-1:0] ptr_q   [NP];

  // switch-traversal registers
  logic [NP-1:0]    vld_q;
  logic [NP*IW-1:0] sel_q;
  logic [NP-1:0]    olock_q;
  logic             err_q;

  // decode and arbitration results
  logic [NP-1:0] legal;
  logic [IW-1:0] dst   [NP];
  logic [NP-1:0] req_m [NP];   // req_m[o][i]: input i is a candidate for o
  logic [NP-1:0] o_gnt;        // output o grants this cycle
  logic [IW-1:0] o_win [NP];   // winning input for output o
  logic [NP-1:0] lock_nxt;
  logic [NP-1:0] gnt_c;

  // Index of the k-th input in the scan that starts at pointer p.
  function automatic logic [IW-1:0] rot_idx(input logic [IW-1:0] p,
                                            input int unsigned k);
    int unsigned s;
    s = (32'(p) + k) % NP;
    return IW'(s);
  endfunction

  // Pointer moves just past the winner, wrapping NP-1 -> 0.
  function automatic logic [IW-1:0] next_ptr(input logic [IW-1:0] w);
    return (32'(w) == NP - 1) ? '0 : w + IW'(1);
  endfunction

  // Route code decode: legal codes are 1..NP, mapping to output code-1.
  always_comb begin
    for (int unsigned i = 0; i < NP; i++) begin
      legal[i] = 1'b0;
      dst[i]   = '0;
      if (bus.in_port[PW*i +: PW] >= PW'(1) &&
          bus.in_port[PW*i +: PW] <= PW'(NP)) begin
        legal[i] = 1'b1;
        dst[i]   = IW'(bus.in_port[PW*i +: PW] - PW'(1));
      end
    end
  end

  always_comb begin
    for (int unsigned o = 0; o < NP; o++) begin
      req_m[o] = '0;
      for (int unsigned i = 0; i < NP; i++) begin
        req_m[o][i] = bus.in_req[i] && legal[i] && (dst[i] == IW'(o));
      end
    end
  end

  // Per-output arbitration. A held output only serves its owner; a free
  // output scans from its round-robin pointer and takes the first
  // candidate, regardless of whether that flit is a head.
  always_comb begin
    o_gnt    = '0;
    gnt_c    = '0;
    lock_nxt = '0;
    for (int unsigned o = 0; o < NP; o++) begin
      o_win[o] = '0;
      if (!rst_t && bus.out_rdy[o]) begin
        if (lock_q[o] == LK_HELD) begin
          if (req_m[o][owner_q[o]]) begin
            o_gnt[o] = 1'b1;
            o_win[o] = owner_q[o];
          end
        end else begin
          for (int unsigned k = 0; k < NP; k++) begin
            if (!o_gnt[o] && req_m[o][rot_idx(ptr_q[o], k)]) begin
              o_gnt[o] = 1'b1;
              o_win[o] = rot_idx(ptr_q[o], k);
            end
          end
        end
      end

      if (o_gnt[o]) begin
        gnt_c[o_win[o]] = 1'b1;
        lock_nxt[o]     = !bus.in_tail[o_win[o]];
      end else begin
        lock_nxt[o]     = (lock_q[o] == LK_HELD);
      end
    end
  end

  // Pointer only moves on grants to a free output, so a locked packet's
  // body and tail flits do not advance it (packet-granularity fairness).
  // A tail grant frees the output at this edge; a head waiting behind it
  // therefore arbitrates on the next cycle from the updated pointer.
  always_ff @(posedge clk_t or posedge rst_t) begin
    if (rst_t) begin
      for (int unsigned o = 0; o < NP; o++) begin
        lock_q[o]  <= LK_FREE;
        owner_q[o] <= '0;
        ptr_q[o]   <= '0;
      end
      vld_q   <= '0;
      sel_q   <= '0;
      olock_q <= '0;
      err_q   <= 1'b0;
    end else begin
      for (int unsigned o = 0; o < NP; o++) begin
        if (o_gnt[o]) begin
          lock_q[o] <= lock_nxt[o] ? LK_HELD : LK_FREE;
          if (lock_nxt[o]) begin
            owner_q[o] <= o_win[o];
          end
          if (lock_q[o] == LK_FREE) begin
            ptr_q[o] <= next_ptr(o_win[o]);
          end
          sel_q[IW*o +: IW] <= o_win[o];
        end
      end
      vld_q   <= o_gnt;
      olock_q <= lock_nxt;
      err_q   <= |(bus.in_req & ~legal);
    end
  end

  assign bus.gnt         = gnt_c;
  assign bus.out_vld     = vld_q;
  assign bus.xbar_sel    = sel_q;
  assign bus.out_lock    = olock_q;
  assign bus.err_illegal = err_q;

endmodule

// File: tb/tb_sw_alloc_rr.sv
// ---------------------------------------------------------------------------
// tb_sw_alloc_rr
//   Directed scoreboard bench for sw_alloc_rr. Each step drives one cycle of
//   requests, checks the combinational grant, pushes the expected
//   switch-traversal outputs, and pops/compares them after the clock edge.
// ---------------------------------------------------------------------------
module tb_sw_alloc_rr;
  localparam int NP = 5;
  localparam int PW = 3;
  localparam int IW = 3;

  logic clk_t = 1'b0;
  logic rst_t;

  sw_alloc_rr_if #(.NP(NP), .PW(PW), .IW(IW)) bus ();

  sw_alloc_rr #(.NP(NP), .PW(PW), .IW(IW)) dut (
    .clk_t (clk_t),
    .rst_t (rst_t),
    .bus   (bus.slave)
  );

  always #5 clk_t = ~clk_t;

  typedef struct packed {
    logic [4:0]  vld;
    logic [14:0] sel;
    logic [4:0]  lock;
    logic        err;
  } exp_t;

  exp_t        exp_q[$];
  logic [14:0] sh_sel;
  logic [2:0]  code [5];
  int          checks;
  int          failures;

  task automatic check(input string tag, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
    end
  endtask

  function automatic int dest(input logic [2:0] c);
    case (c)
      3'b001:  return 0;
      3'b010:  return 1;
      3'b011:  return 2;
      3'b100:  return 3;
      3'b101:  return 4;
      default: return -1;
    endcase
  endfunction

  task automatic pop_check(input string tag);
    exp_t e;
    if (exp_q.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      check({tag, "_vld"},  32'(bus.out_vld),     32'(e.vld));
      check({tag, "_sel"},  32'(bus.xbar_sel),    32'(e.sel));
      check({tag, "_lock"}, 32'(bus.out_lock),    32'(e.lock));
      check({tag, "_err"},  32'(bus.err_illegal), 32'(e.err));
    end
  endtask

  task automatic step(input string tag, input logic [4:0] req,
                      input logic [4:0] head, input logic [4:0] tail,
                      input logic [4:0] rdy, input logic [4:0] exp_gnt,
                      input logic [4:0] exp_lock, input logic exp_err);
    exp_t e;
    int   d;
    @(negedge clk_t);
    bus.in_req  = req;
    bus.in_head = head;
    bus.in_tail = tail;
    bus.out_rdy = rdy;
    for (int i = 0; i < 5; i++) bus.in_port[3*i +: 3] = code[i];
    #1;
    check({tag, "_gnt"}, 32'(bus.gnt), 32'(exp_gnt));
    e.vld = '0;
    for (int i = 0; i < 5; i++) begin
      if (exp_gnt[i]) begin
        d = dest(code[i]);
        if (d >= 0) begin
          e.vld[d]         = 1'b1;
          sh_sel[3*d +: 3] = 3'(i);
        end
      end
    end
    e.sel  = sh_sel;
    e.lock = exp_lock;
    e.err  = exp_err;
    exp_q.push_back(e);
    @(posedge clk_t);
    #1;
    pop_check(tag);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_gnt"},  32'(bus.gnt),         32'd0);
    check({tag, "_vld"},  32'(bus.out_vld),     32'd0);
    check({tag, "_sel"},  32'(bus.xbar_sel),    32'd0);
    check({tag, "_lock"}, 32'(bus.out_lock),    32'd0);
    check({tag, "_err"},  32'(bus.err_illegal), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    checks      = 0;
    failures    = 0;
    sh_sel      = '0;
    for (int i = 0; i < 5; i++) code[i] = 3'b000;
    rst_t       = 1'b1;
    bus.in_req  = '0;
    bus.in_port = '0;
    bus.in_head = '0;
    bus.in_tail = '0;
    bus.out_rdy = '1;
    #3;
    check_all_zero("reset");
    @(negedge clk_t);
    @(negedge clk_t);
    rst_t = 1'b0;

    // idle after reset
    for (int n = 0; n < 3; n++)
      step("idle", 5'b00000, 5'b00000, 5'b00000, 5'b11111, 5'b00000, 5'b00000, 1'b0);

    // single-flit LOCAL -> EAST
    code[0] = 3'b010;
    step("single", 5'b00001, 5'b00001, 5'b00001, 5'b11111, 5'b00001, 5'b00000, 1'b0);

    // round robin: inputs 1,2,3 single flits to NORTH
    code[0] = 3'b000;
    code[1] = 3'b100; code[2] = 3'b100; code[3] = 3'b100;
    step("rr_a", 5'b01110, 5'b01110, 5'b01110, 5'b11111, 5'b00010, 5'b00000, 1'b0);
    step("rr_b", 5'b01110, 5'b01110, 5'b01110, 5'b11111, 5'b00100, 5'b00000, 1'b0);
    step("rr_c", 5'b01110, 5'b01110, 5'b01110, 5'b11111, 5'b01000, 5'b00000, 1'b0);
    step("rr_d", 5'b01110, 5'b01110, 5'b01110, 5'b11111, 5'b00010, 5'b00000, 1'b0);
    step("rr_e", 5'b01110, 5'b01110, 5'b01110, 5'b11111, 5'b00100, 5'b00000, 1'b0);
    step("rr_f", 5'b01110, 5'b01110, 5'b01110, 5'b11111, 5'b01000, 5'b00000, 1'b0);

    // wormhole: input 2 packet to SOUTH, input 4 single flit waits
    code[1] = 3'b000; code[3] = 3'b000;
    code[2] = 3'b101; code[4] = 3'b101;
    step("wh_head", 5'b10100, 5'b10100, 5'b10000, 5'b11111, 5'b00100, 5'b10000, 1'b0);
    step("wh_body1", 5'b10100, 5'b10000, 5'b10000, 5'b11111, 5'b00100, 5'b10000, 1'b0);
    step("wh_body2", 5'b10100, 5'b10000, 5'b10000, 5'b11111, 5'b00100, 5'b10000, 1'b0);
    step("wh_tail", 5'b10100, 5'b10000, 5'b10100, 5'b11111, 5'b00100, 5'b00000, 1'b0);
    step("wh_next", 5'b10000, 5'b10000, 5'b10000, 5'b11111, 5'b10000, 5'b00000, 1'b0);

    // backpressure on NORTH mid-packet, plus an illegal UP request
    code[2] = 3'b000; code[4] = 3'b000;
    code[0] = 3'b100; code[1] = 3'b100;
    step("bp_head", 5'b00011, 5'b00011, 5'b00010, 5'b11111, 5'b00001, 5'b01000, 1'b0);
    code[3] = 3'b110;
    step("bp_stall1", 5'b01011, 5'b01010, 5'b01010, 5'b10111, 5'b00000, 5'b01000, 1'b1);
    code[3] = 3'b000;
    step("bp_stall2", 5'b00011, 5'b00010, 5'b00010, 5'b10111, 5'b00000, 5'b01000, 1'b0);
    step("bp_stall3", 5'b00011, 5'b00010, 5'b00010, 5'b10111, 5'b00000, 5'b01000, 1'b0);
    step("bp_tail", 5'b00011, 5'b00011, 5'b00011, 5'b11111, 5'b00001, 5'b00000, 1'b0);
    step("bp_next", 5'b00010, 5'b00010, 5'b00010, 5'b11111, 5'b00010, 5'b00000, 1'b0);

    // illegal codes 111, 110, 000
    code[0] = 3'b111; code[1] = 3'b000; code[3] = 3'b110; code[4] = 3'b000;
    step("illegal", 5'b11001, 5'b11001, 5'b11001, 5'b11111, 5'b00000, 5'b00000, 1'b1);
    step("illegal_clr", 5'b00000, 5'b00000, 5'b00000, 5'b11111, 5'b00000, 5'b00000, 1'b0);

    // reset in the middle of a packet on EAST
    code[0] = 3'b000; code[3] = 3'b010;
    step("mr_head", 5'b01000, 5'b01000, 5'b00000, 5'b11111, 5'b01000, 5'b00010, 1'b0);
    #2;
    rst_t = 1'b1;
    #1;
    check_all_zero("mr_reset");
    sh_sel = '0;
    bus.in_req = '0;
    @(negedge clk_t);
    @(negedge clk_t);
    rst_t = 1'b0;
    code[1] = 3'b010; code[4] = 3'b010;
    step("mr_after", 5'b10010, 5'b10010, 5'b00000, 5'b11111, 5'b00010, 5'b00010, 1'b0);
    step("mr_tail", 5'b00010, 5'b00000, 5'b00010, 5'b11111, 5'b00010, 5'b00000, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
